// File: rtl/uart_tx_fifo_pkg.sv
// rtl/uart_tx_fifo_pkg.sv - shared UART constants and read-side FSM state encoding
package uart_tx_fifo_pkg;

   localparam int UART_DATA_W = 8;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_WAIT_ACK  = 2'd1,
      ST_WAIT_DONE = 2'd2
   } fsm_state_t;

endpackage

// File: rtl/uart_tx_fifo_if.sv
// rtl/uart_tx_fifo_if.sv - receiver/transmitter handshake bundle around the TX byte FIFO
interface uart_tx_fifo_if #(
   parameter int DEPTH  = 16,
   parameter int DATA_W = 8
);
   logic [DATA_W-1:0]        rx_data;
   logic                     rx_valid;
   logic                     tx_busy;
   logic [DATA_W-1:0]        tx_data;
   logic                     tx_start;
   logic [$clog2(DEPTH):0]   count;
   logic                     full;
   logic                     empty;
   logic                     overflow;

   // Receiver/transmitter side: supplies bytes and busy, observes FIFO status
   modport master (
      output rx_data, rx_valid, tx_busy,
      input  tx_data, tx_start, count, full, empty, overflow
   );

   // FIFO side
   modport slave (
      input  rx_data, rx_valid, tx_busy,
      output tx_data, tx_start, count, full, empty, overflow
   );
endinterface

// File: rtl/uart_fifo_mem.sv
// rtl/uart_fifo_mem.sv - DEPTH x DATA_W register array, sync write, async read
module uart_fifo_mem #(
   parameter int DEPTH  = 16,
   parameter int DATA_W = 8
) (
   input  logic                     clk,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] wr_addr,
   input  logic [DATA_W-1:0]        wr_data,
   input  logic [$clog2(DEPTH)-1:0] rd_addr,
   output logic [DATA_W-1:0]        rd_data
);
   logic [DATA_W-1:0] mem [DEPTH];

   // Storage is not reset; the pointers alone decide what is valid
   always_ff @(posedge clk) begin
      if (we) mem[wr_addr] <= wr_data;
   end

   assign rd_data = mem[rd_addr];
endmodule

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - RX-to-TX byte FIFO with start/busy drain FSM; optional UART_TX_FIFO_DROPCNT_EN drop counter
module uart_tx_fifo
   import uart_tx_fifo_pkg::*;
#(
   parameter int DEPTH  = 16,
   parameter int DATA_W = UART_DATA_W
) (
   input  logic          clk,
   input  logic          reset,
   uart_tx_fifo_if.slave bus
`ifdef UART_TX_FIFO_DROPCNT_EN
   ,
   output logic [7:0]    drop_cnt
`endif
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   fsm_state_t        state, state_nxt;
   logic [AW-1:0]     wr_ptr, rd_ptr;
   logic [CW-1:0]     count_q, count_nxt;
   logic              full_q, empty_q, overflow_q;
   logic              tx_start_q;
   logic [DATA_W-1:0] tx_data_q, rd_data;
   logic              push, pop, drop, launch;

   // A byte leaves the FIFO during the cycle tx_start is high, which frees a slot for a same-cycle write
   assign pop  = tx_start_q;
   assign push = bus.rx_valid && (!full_q || pop);
   assign drop = bus.rx_valid && full_q && !pop;

   uart_fifo_mem #(.DEPTH(DEPTH), .DATA_W(DATA_W)) u_mem (
      .clk     (clk),
      .we      (push),
      .wr_addr (wr_ptr),
      .wr_data (bus.rx_data),
      .rd_addr (rd_ptr),
      .rd_data (rd_data)
   );

   // Next occupancy from this cycle's push/pop
   always_comb begin
      count_nxt = count_q;
      if (push && !pop)      count_nxt = count_q + CW'(1);
      else if (pop && !push) count_nxt = count_q - CW'(1);
   end

   // Pointers, registered occupancy flags and overflow pulse
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count_q    <= '0;
         full_q     <= 1'b0;
         empty_q    <= 1'b1;
         overflow_q <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         count_q    <= count_nxt;
         full_q     <= (count_nxt == DEPTH_C);
         empty_q    <= (count_nxt == '0);
         overflow_q <= drop;
      end
   end

   // Drain FSM: launch only from IDLE with the transmitter idle, then track its busy window
   always_comb begin
      state_nxt = state;
      launch    = 1'b0;
      case (state)
         ST_IDLE: begin
            if (!empty_q && !bus.tx_busy) begin
               launch    = 1'b1;
               state_nxt = ST_WAIT_ACK;
            end
         end
         ST_WAIT_ACK:  if (bus.tx_busy)  state_nxt = ST_WAIT_DONE;
         ST_WAIT_DONE: if (!bus.tx_busy) state_nxt = ST_IDLE;
         default:      state_nxt = ST_IDLE;
      endcase
   end

   // FSM state plus the registered tx_start pulse and held tx_data
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= ST_IDLE;
         tx_start_q <= 1'b0;
         tx_data_q  <= '0;
      end else begin
         state      <= state_nxt;
         tx_start_q <= launch;
         if (launch) tx_data_q <= rd_data;
      end
   end

`ifdef UART_TX_FIFO_DROPCNT_EN
   // Saturating count of dropped bytes
   always_ff @(posedge clk) begin
      if (reset)                        drop_cnt <= 8'd0;
      else if (drop && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
   end
`endif

   assign bus.tx_data  = tx_data_q;
   assign bus.tx_start = tx_start_q;
   assign bus.count    = count_q;
   assign bus.full     = full_q;
   assign bus.empty    = empty_q;
   assign bus.overflow = overflow_q;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - directed vector and sequence bench for uart_tx_fifo
module tb_uart_tx_fifo;
   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   uart_tx_fifo_if #(.DEPTH(16), .DATA_W(8)) bus ();

`ifdef UART_TX_FIFO_DROPCNT_EN
   logic [7:0] drop_cnt;
`endif

   uart_tx_fifo #(.DEPTH(16), .DATA_W(8)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
`ifdef UART_TX_FIFO_DROPCNT_EN
      ,
      .drop_cnt (drop_cnt)
`endif
   );

   int compared = 0;
   int mismatched = 0;

   // transmitter model: busy for busy_len cycles starting the cycle after tx_start
   logic busy_hold = 1'b1;
   logic model_en = 1'b0;
   int   busy_len = 16;
   int   busy_cnt = 0;
   int   cyc = 0;
   assign bus.tx_busy = busy_hold || (model_en && busy_cnt != 0);

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (model_en && bus.tx_start) busy_cnt <= busy_len;
      else if (busy_cnt != 0)       busy_cnt <= busy_cnt - 1;
   end

   // output monitor
   logic [7:0] got[$];
   int         got_cyc[$];
   int         ovf_n = 0;
   int         fall_cyc = 0;
   logic       prev_busy = 1'b0;
   always @(negedge clk) begin
      if (bus.tx_start) begin
         got.push_back(bus.tx_data);
         got_cyc.push_back(cyc);
      end
      if (bus.overflow) ovf_n++;
      if (prev_busy && !bus.tx_busy) fall_cyc = cyc;
      prev_busy = bus.tx_busy;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic send(input logic [7:0] b);
      @(negedge clk);
      bus.rx_valid = 1'b1;
      bus.rx_data  = b;
      @(negedge clk);
      bus.rx_valid = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic wait_got(input int n, input int budget, input string name);
      int k = 0;
      while (got.size() < n && k < budget) begin
         @(negedge clk);
         k++;
      end
      check(name, got.size(), n);
   endtask

   task automatic wait_idle(input int budget);
      int k = 0;
      while ((bus.tx_busy || !bus.empty) && k < budget) begin
         @(negedge clk);
         k++;
      end
      check("idle_timeout", (bus.tx_busy || !bus.empty), 0);
      repeat (4) @(negedge clk);
   endtask

   typedef struct packed {
      logic       rst;
      logic       rxv;
      logic [7:0] rxd;
      logic       busy;
      logic [4:0] e_count;
      logic       e_empty;
      logic       e_full;
      logic       e_start;
      logic       e_ovf;
      logic [7:0] e_data;
   } vec_t;

   vec_t vec [14];

   initial begin
      int base;
      int ob;
      bus.rx_valid = 1'b0;
      bus.rx_data  = 8'h00;

      // rst rxv rxd busy | count empty full start ovf data
      vec[0]  = '{1'b1, 1'b0, 8'h00, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
      vec[1]  = '{1'b0, 1'b1, 8'hA5, 1'b1, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
      vec[2]  = '{1'b0, 1'b1, 8'h5A, 1'b1, 5'd2, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
      vec[3]  = '{1'b0, 1'b0, 8'h00, 1'b1, 5'd2, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
      vec[4]  = '{1'b0, 1'b0, 8'h00, 1'b0, 5'd2, 1'b0, 1'b0, 1'b1, 1'b0, 8'hA5};
      vec[5]  = '{1'b0, 1'b1, 8'h11, 1'b0, 5'd2, 1'b0, 1'b0, 1'b0, 1'b0, 8'hA5};
      vec[6]  = '{1'b0, 1'b0, 8'h00, 1'b1, 5'd2, 1'b0, 1'b0, 1'b0, 1'b0, 8'hA5};
      vec[7]  = '{1'b0, 1'b0, 8'h00, 1'b0, 5'd2, 1'b0, 1'b0, 1'b0, 1'b0, 8'hA5};
      vec[8]  = '{1'b0, 1'b0, 8'h00, 1'b0, 5'd2, 1'b0, 1'b0, 1'b1, 1'b0, 8'h5A};
      vec[9]  = '{1'b0, 1'b0, 8'h00, 1'b1, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h5A};
      vec[10] = '{1'b0, 1'b0, 8'h00, 1'b0, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h5A};
      vec[11] = '{1'b0, 1'b0, 8'h00, 1'b1, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h5A};
      vec[12] = '{1'b1, 1'b0, 8'h00, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
      vec[13] = '{1'b0, 1'b0, 8'h00, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};

      for (int i = 0; i < 14; i++) begin
         @(negedge clk);
         reset        = vec[i].rst;
         bus.rx_valid = vec[i].rxv;
         bus.rx_data  = vec[i].rxd;
         busy_hold    = vec[i].busy;
         @(posedge clk);
         #1;
         check($sformatf("v%0d_count", i), bus.count, vec[i].e_count);
         check($sformatf("v%0d_empty", i), bus.empty, vec[i].e_empty);
         check($sformatf("v%0d_full", i), bus.full, vec[i].e_full);
         check($sformatf("v%0d_start", i), bus.tx_start, vec[i].e_start);
         check($sformatf("v%0d_ovf", i), bus.overflow, vec[i].e_ovf);
         check($sformatf("v%0d_data", i), bus.tx_data, vec[i].e_data);
      end
      @(negedge clk);
      reset = 1'b0;
      bus.rx_valid = 1'b0;
      busy_hold = 1'b0;
      model_en = 1'b1;

      // single byte: tx_start two cycles after rx_valid
      do_reset();
      busy_len = 16;
      base = got.size();
      begin
         int rx_c;
         @(negedge clk);
         bus.rx_valid = 1'b1;
         bus.rx_data  = 8'h41;
         rx_c = cyc;
         @(negedge clk);
         bus.rx_valid = 1'b0;
         wait_got(base + 1, 50, "t1_timeout");
         if (got.size() > base) begin
            check("t1_data", got[base], 8'h41);
            check("t1_latency", got_cyc[base] - rx_c, 2);
         end
      end
      wait_idle(200);
      check("t1_count", bus.count, 0);
      check("t1_empty", bus.empty, 1);

      // burst ordering with a full-length 9600-baud busy window
      busy_len = 10416;
      base = got.size();
      send(8'h41); repeat (9) @(negedge clk);
      send(8'h42); repeat (9) @(negedge clk);
      send(8'h31); repeat (9) @(negedge clk);
      send(8'h30);
      wait_got(base + 4, 45000, "t2_timeout");
      if (got.size() >= base + 4) begin
         check("t2_b0", got[base], 8'h41);
         check("t2_b1", got[base + 1], 8'h42);
         check("t2_b2", got[base + 2], 8'h31);
         check("t2_b3", got[base + 3], 8'h30);
         for (int i = 1; i < 4; i++)
            check($sformatf("t2_spacing%0d", i), (got_cyc[base + i] - got_cyc[base + i - 1]) >= 10418, 1);
      end
      wait_idle(11000);

      // full and overflow with the transmitter held busy
      busy_len = 8;
      @(negedge clk);
      busy_hold = 1'b1;
      base = got.size();
      ob = ovf_n;
      for (int i = 0; i < 16; i++) begin
         send(8'(i));
         if (i == 14) check("t3_notfull15", bus.full, 0);
      end
      check("t3_full16", bus.full, 1);
      check("t3_count16", bus.count, 16);
      send(8'h10);
      @(negedge clk);
      check("t3_ovf_pulses", ovf_n - ob, 1);
      check("t3_count_after_drop", bus.count, 16);
`ifdef UART_TX_FIFO_DROPCNT_EN
      check("t3_drop_cnt", drop_cnt, 1);
`endif
      busy_hold = 1'b0;
      wait_got(base + 16, 1000, "t3_timeout");
      wait_idle(500);
      check("t3_nodrop_leak", got.size(), base + 16);
      for (int i = 0; i < 16; i++)
         if (got.size() > base + i) check($sformatf("t3_b%0d", i), got[base + i], 8'(i));

      // push and pop in the same cycle while full
      @(negedge clk);
      busy_hold = 1'b1;
      base = got.size();
      ob = ovf_n;
      for (int i = 0; i < 16; i++) send(8'h80 + 8'(i));
      check("t4_full", bus.full, 1);
      busy_hold = 1'b0;
      @(negedge clk);
      check("t4_start_seen", bus.tx_start, 1);
      bus.rx_valid = 1'b1;
      bus.rx_data  = 8'hC0;
      @(negedge clk);
      bus.rx_valid = 1'b0;
      check("t4_no_ovf", ovf_n - ob, 0);
      check("t4_count", bus.count, 16);
      wait_got(base + 17, 1000, "t4_timeout");
      wait_idle(500);
      if (got.size() >= base + 17) begin
         check("t4_first", got[base], 8'h80);
         check("t4_16th", got[base + 15], 8'h8F);
         check("t4_last", got[base + 16], 8'hC0);
      end

      // reset while the transmitter is busy
      busy_len = 50;
      base = got.size();
      send(8'hA1); send(8'hA2); send(8'hA3);
      wait_got(base + 1, 50, "t5_first_timeout");
      repeat (5) @(negedge clk);
      check("t5_busy_before_reset", bus.tx_busy, 1);
      do_reset();
      begin
         int rst_c;
         rst_c = cyc;
         check("t5_count", bus.count, 0);
         check("t5_empty", bus.empty, 1);
         check("t5_start", bus.tx_start, 0);
         check("t5_data", bus.tx_data, 0);
         send(8'h77);
         wait_got(base + 2, 200, "t5_new_timeout");
         if (got.size() >= base + 2) begin
            check("t5_new_byte", got[base + 1], 8'h77);
            check("t5_busy_fell_after_reset", fall_cyc > rst_c, 1);
            check("t5_start_after_busy_low", got_cyc[base + 1] > fall_cyc, 1);
         end
      end
      wait_idle(300);
      check("t5_no_stale", got.size(), base + 2);

      // wrap-around with a slow drain
      busy_len = 30;
      base = got.size();
      ob = ovf_n;
      for (int i = 0; i < 40; i++) begin
         send(8'h20 + 8'(i));
         repeat (24) @(negedge clk);
      end
      wait_got(base + 40, 3000, "t6_timeout");
      wait_idle(500);
      check("t6_total", got.size(), base + 40);
      check("t6_no_ovf", ovf_n - ob, 0);
      for (int i = 0; i < 40; i++)
         if (got.size() > base + i) check($sformatf("t6_b%0d", i), got[base + i], 8'h20 + 8'(i));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
